// File: rtl/channel_reg_bank_pkg.sv
// Shared constants and helpers for the channel register bank.
package channel_reg_pkg;

  localparam int PARAM_W    = 24;
  localparam int MIN_STRIDE = 22;
  localparam int OFF_COUNT  = 22;   // offsets 0x00..0x15 are mapped inside a channel window

  // Per-channel register offsets
  localparam logic [4:0] OFF_GATE       = 5'h00;
  localparam logic [4:0] OFF_INCR       = 5'h01;
  localparam logic [4:0] OFF_WAVETYPE   = 5'h04;
  localparam logic [4:0] OFF_PULSEWIDTH = 5'h05;
  localparam logic [4:0] OFF_ATTACK     = 5'h08;
  localparam logic [4:0] OFF_DECAY      = 5'h0B;
  localparam logic [4:0] OFF_SUSTAIN    = 5'h0E;
  localparam logic [4:0] OFF_RELEASE    = 5'h11;
  localparam logic [4:0] OFF_LINEAR     = 5'h14;
  localparam logic [4:0] OFF_STATUS     = 5'h15;

  // Global window offsets
  localparam logic [1:0] G_GATESET = 2'd0;
  localparam logic [1:0] G_GATECLR = 2'd1;
  localparam logic [1:0] G_ID      = 2'd2;

  // Which byte of a 24-bit field an offset addresses
  typedef enum logic [1:0] {
    PB_LO   = 2'd0,
    PB_MID  = 2'd1,
    PB_HI   = 2'd2,
    PB_NONE = 2'd3
  } param_byte_e;

  function automatic param_byte_e param_byte(input logic [4:0] off);
    param_byte_e pb;
    pb = PB_NONE;
    case (off)
      OFF_INCR, OFF_PULSEWIDTH, OFF_ATTACK,
      OFF_DECAY, OFF_SUSTAIN, OFF_RELEASE:                    pb = PB_LO;
      OFF_INCR + 5'd1, OFF_PULSEWIDTH + 5'd1, OFF_ATTACK + 5'd1,
      OFF_DECAY + 5'd1, OFF_SUSTAIN + 5'd1, OFF_RELEASE + 5'd1: pb = PB_MID;
      OFF_INCR + 5'd2, OFF_PULSEWIDTH + 5'd2, OFF_ATTACK + 5'd2,
      OFF_DECAY + 5'd2, OFF_SUSTAIN + 5'd2, OFF_RELEASE + 5'd2: pb = PB_HI;
      default:                                                  pb = PB_NONE;
    endcase
    return pb;
  endfunction

endpackage

// File: rtl/channel_reg_bank_if.sv
// Byte-wide bus between the master and the channel register bank.
interface channel_reg_bank_if;
  logic        BusValid;
  logic        BusReadWrite;
  logic [15:0] BusAddress;
  logic [7:0]  BusDataIn;
  logic [7:0]  BusDataOut;
  logic        BusDataOE;
  logic        BusError;

  modport master (
    output BusValid, BusReadWrite, BusAddress, BusDataIn,
    input  BusDataOut, BusDataOE, BusError
  );

  modport slave (
    input  BusValid, BusReadWrite, BusAddress, BusDataIn,
    output BusDataOut, BusDataOE, BusError
  );
endinterface

// File: rtl/channel_reg_bank_channel_regs.sv
// One channel's control fields, its write decode and its readback mux.
module channel_regs
  import channel_reg_pkg::*;
(
  input  logic               BusClock,
  input  logic               Reset,
  input  logic               wr,
  input  logic [4:0]         off,
  input  logic [7:0]         data,
  input  logic [15:0]        stage,
  input  logic               gate_set,
  input  logic               gate_clr,
  input  logic               running,
  input  logic [1:0]         adsr_state,
  output logic               gate,
  output logic               linear,
  output logic [1:0]         wave_type,
  output logic [PARAM_W-1:0] incr,
  output logic [PARAM_W-1:0] pulse_width,
  output logic [PARAM_W-1:0] attack,
  output logic [PARAM_W-1:0] decay,
  output logic [PARAM_W-1:0] sustain,
  output logic [PARAM_W-1:0] release_time,
  output logic [7:0]         rd_data
);

  // Field registers: global gate set/clear, then direct writes; byte 2 commits a 24-bit field.
  // NOTE: Reset is sampled only at the clock edge (synchronous), so it sits inside the
  // posedge block rather than in the sensitivity list; all state uses <= so every register
  // sees pre-edge values of its neighbours.
  always_ff @(posedge BusClock) begin
    if (!Reset) begin
      gate         <= 1'b0;
      linear       <= 1'b0;
      wave_type    <= '0;
      incr         <= '0;
      pulse_width  <= '0;
      attack       <= '0;
      decay        <= '0;
      sustain      <= '0;
      release_time <= '0;
    end else begin
      gate <= (gate | gate_set) & ~gate_clr;
      if (wr) begin
        case (off)
          OFF_GATE:                gate         <= data[0];
          OFF_WAVETYPE:            wave_type    <= data[1:0];
          OFF_LINEAR:              linear       <= data[0];
          OFF_INCR + 5'd2:         incr         <= {data, stage};
          OFF_PULSEWIDTH + 5'd2:   pulse_width  <= {data, stage};
          OFF_ATTACK + 5'd2:       attack       <= {data, stage};
          OFF_DECAY + 5'd2:        decay        <= {data, stage};
          OFF_SUSTAIN + 5'd2:      sustain      <= {data, stage};
          OFF_RELEASE + 5'd2:      release_time <= {data, stage};
          default: ;
        endcase
      end
    end
  end

  // Readback mux: committed field bytes and live status, never the staging register.
  // NOTE: rd_data gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    rd_data = 8'h00;
    case (off)
      OFF_GATE:              rd_data = {7'b0, gate};
      OFF_INCR:              rd_data = incr[7:0];
      OFF_INCR + 5'd1:       rd_data = incr[15:8];
      OFF_INCR + 5'd2:       rd_data = incr[23:16];
      OFF_WAVETYPE:          rd_data = {6'b0, wave_type};
      OFF_PULSEWIDTH:        rd_data = pulse_width[7:0];
      OFF_PULSEWIDTH + 5'd1: rd_data = pulse_width[15:8];
      OFF_PULSEWIDTH + 5'd2: rd_data = pulse_width[23:16];
      OFF_ATTACK:            rd_data = attack[7:0];
      OFF_ATTACK + 5'd1:     rd_data = attack[15:8];
      OFF_ATTACK + 5'd2:     rd_data = attack[23:16];
      OFF_DECAY:             rd_data = decay[7:0];
      OFF_DECAY + 5'd1:      rd_data = decay[15:8];
      OFF_DECAY + 5'd2:      rd_data = decay[23:16];
      OFF_SUSTAIN:           rd_data = sustain[7:0];
      OFF_SUSTAIN + 5'd1:    rd_data = sustain[15:8];
      OFF_SUSTAIN + 5'd2:    rd_data = sustain[23:16];
      OFF_RELEASE:           rd_data = release_time[7:0];
      OFF_RELEASE + 5'd1:    rd_data = release_time[15:8];
      OFF_RELEASE + 5'd2:    rd_data = release_time[23:16];
      OFF_LINEAR:            rd_data = {7'b0, linear};
      OFF_STATUS:            rd_data = {5'b0, adsr_state, running};
      default:               rd_data = 8'h00;
    endcase
  end

endmodule

// File: rtl/channel_reg_bank.sv
// Register bank for NUM_CHANNELS synth channels: address decode, shared staging,
// global gate set/clear, registered read/error response.
module channel_reg_bank #(
  parameter int          NUM_CHANNELS = 4,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter int          STRIDE       = 32,
  parameter int          PARAM_W      = channel_reg_pkg::PARAM_W
) (
  input  logic                        BusClock,
  input  logic                        Reset,
  channel_reg_bank_if.slave           bus,
  input  logic [NUM_CHANNELS-1:0]     Running,
  input  logic [2*NUM_CHANNELS-1:0]   ADSRState,
  output logic [NUM_CHANNELS-1:0]     Gate,
  output logic [NUM_CHANNELS-1:0]     Linear,
  output logic [2*NUM_CHANNELS-1:0]   WaveType,
  output logic [PARAM_W*NUM_CHANNELS-1:0] Incr,
  output logic [PARAM_W*NUM_CHANNELS-1:0] PulseWidth,
  output logic [PARAM_W*NUM_CHANNELS-1:0] Attack,
  output logic [PARAM_W*NUM_CHANNELS-1:0] Decay,
  output logic [PARAM_W*NUM_CHANNELS-1:0] Sustain,
  output logic [PARAM_W*NUM_CHANNELS-1:0] Release
);
  import channel_reg_pkg::*;

  localparam logic [31:0] BANK_SPAN = 32'(NUM_CHANNELS * STRIDE);

  logic [31:0]             rel, off, glob_off;
  logic                    in_bank, is_glob, mapped;
  logic [4:0]              off5;
  logic [NUM_CHANNELS-1:0] ch_hit, ch_wr, gate_set, gate_clr;
  logic [7:0]              ch_rd [NUM_CHANNELS];
  logic [7:0]              ch_rd_sel;
  logic                    wr_txn, rd_txn;
  logic [15:0]             stage;
  logic [7:0]              resp_data, data_q;
  logic                    resp_oe, resp_err, oe_q, err_q;

  // Address decode: which channel window (if any) and the offset within it.
  always_comb begin
    rel     = {16'h0, bus.BusAddress} - {16'h0, BASE_ADDR};
    in_bank = (bus.BusAddress >= BASE_ADDR);
    ch_hit  = '0;
    off     = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (in_bank && rel >= 32'(i * STRIDE) && rel < 32'((i + 1) * STRIDE)) begin
        ch_hit[i] = 1'b1;
        off       = rel - 32'(i * STRIDE);
      end
    end
    glob_off = rel - BANK_SPAN;
    is_glob  = in_bank && (rel >= BANK_SPAN) && (rel < BANK_SPAN + 32'd3);
    mapped   = (off < 32'(OFF_COUNT));
    off5     = off[4:0];
    wr_txn   = bus.BusValid & bus.BusReadWrite;
    rd_txn   = bus.BusValid & ~bus.BusReadWrite;
  end

  // Per-channel write strobes and global gate set/clear masks.
  always_comb begin
    ch_wr    = '0;
    gate_set = '0;
    gate_clr = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      ch_wr[i] = wr_txn & ch_hit[i] & mapped & (off5 != OFF_STATUS);
    if (wr_txn && is_glob && glob_off == 32'(G_GATESET))
      gate_set = bus.BusDataIn[NUM_CHANNELS-1:0];
    if (wr_txn && is_glob && glob_off == 32'(G_GATECLR))
      gate_clr = bus.BusDataIn[NUM_CHANNELS-1:0];
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    channel_regs u_regs (
      .BusClock     (BusClock),
      .Reset        (Reset),
      .wr           (ch_wr[i]),
      .off          (off5),
      .data         (bus.BusDataIn),
      .stage        (stage),
      .gate_set     (gate_set[i]),
      .gate_clr     (gate_clr[i]),
      .running      (Running[i]),
      .adsr_state   (ADSRState[2*i +: 2]),
      .gate         (Gate[i]),
      .linear       (Linear[i]),
      .wave_type    (WaveType[2*i +: 2]),
      .incr         (Incr[i*PARAM_W +: PARAM_W]),
      .pulse_width  (PulseWidth[i*PARAM_W +: PARAM_W]),
      .attack       (Attack[i*PARAM_W +: PARAM_W]),
      .decay        (Decay[i*PARAM_W +: PARAM_W]),
      .sustain      (Sustain[i*PARAM_W +: PARAM_W]),
      .release_time (Release[i*PARAM_W +: PARAM_W]),
      .rd_data      (ch_rd[i])
    );
  end

  // Select the addressed channel's readback byte (ch_hit is one-hot or zero).
  always_comb begin
    ch_rd_sel = 8'h00;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (ch_hit[i]) ch_rd_sel = ch_rd[i];
  end

  // Shared staging register for the low two bytes of any 24-bit field.
  always_ff @(posedge BusClock) begin
    if (!Reset) begin
      stage <= '0;
    end else if (wr_txn && (|ch_hit) && mapped) begin
      case (param_byte(off5))
        PB_LO:   stage[7:0]  <= bus.BusDataIn;
        PB_MID:  stage[15:8] <= bus.BusDataIn;
        default: ;
      endcase
    end
  end

  // Response for this cycle's transaction: read data, OE and error flag.
  always_comb begin
    resp_data = 8'h00;
    resp_oe   = 1'b0;
    resp_err  = 1'b0;
    if (|ch_hit) begin
      if (mapped) begin
        resp_err  = wr_txn && (off5 == OFF_STATUS);
        resp_oe   = rd_txn;
        resp_data = rd_txn ? ch_rd_sel : 8'h00;
      end else begin
        resp_err = bus.BusValid;
        resp_oe  = rd_txn;
      end
    end else if (is_glob) begin
      if (glob_off == 32'(G_ID)) begin
        resp_err  = wr_txn;
        resp_oe   = rd_txn;
        resp_data = rd_txn ? 8'(NUM_CHANNELS) : 8'h00;
      end else begin
        resp_err = rd_txn;
        resp_oe  = rd_txn;
      end
    end
  end

  // Read pipeline register: the response is presented for exactly the following cycle.
  always_ff @(posedge BusClock) begin
    if (!Reset) begin
      data_q <= 8'h00;
      oe_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      data_q <= resp_data;
      oe_q   <= resp_oe;
      err_q  <= resp_err;
    end
  end

  assign bus.BusDataOut = data_q;
  assign bus.BusDataOE  = oe_q;
  assign bus.BusError   = err_q;

endmodule

// File: tb/tb_channel_reg_bank.sv
// Directed self-checking bench for channel_reg_bank (4 channels, base 0x0000, stride 0x20).
module tb_channel_reg_bank;

  localparam int N = 4;
  localparam int W = 24;

  logic              BusClock = 1'b0;
  logic              Reset;
  logic [N-1:0]      Running;
  logic [2*N-1:0]    ADSRState;
  logic [N-1:0]      Gate, Linear;
  logic [2*N-1:0]    WaveType;
  logic [W*N-1:0]    Incr, PulseWidth, Attack, Decay, Sustain, Release;

  int n_checks = 0;
  int n_errors = 0;

  channel_reg_bank_if bus ();

  channel_reg_bank #(
    .NUM_CHANNELS (N),
    .BASE_ADDR    (16'h0000),
    .STRIDE       (32)
  ) dut (
    .BusClock   (BusClock),
    .Reset      (Reset),
    .bus        (bus),
    .Running    (Running),
    .ADSRState  (ADSRState),
    .Gate       (Gate),
    .Linear     (Linear),
    .WaveType   (WaveType),
    .Incr       (Incr),
    .PulseWidth (PulseWidth),
    .Attack     (Attack),
    .Decay      (Decay),
    .Sustain    (Sustain),
    .Release    (Release)
  );

  always #5 BusClock = ~BusClock;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's bus inputs at the falling edge; the returning negedge is mid-cycle t+1.
  task automatic drive(input logic v, input logic rw, input logic [15:0] a, input logic [7:0] d);
    @(negedge BusClock);
    bus.BusValid     = v;
    bus.BusReadWrite = rw;
    bus.BusAddress   = a;
    bus.BusDataIn    = d;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    drive(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [15:0] a);
    drive(1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset     = 1'b0;
    Running   = '0;
    ADSRState = '0;
    bus.BusValid = 1'b0; bus.BusReadWrite = 1'b0; bus.BusAddress = '0; bus.BusDataIn = '0;

    // Reset, with a GateSet write in flight that reset must override
    wr(16'h0080, 8'hFF);
    wr(16'h0080, 8'hFF);
    @(negedge BusClock);
    Reset = 1'b1;
    bus.BusValid = 1'b0;
    check("rst_gate", Gate, 0);
    check("rst_fields", {|Incr, |PulseWidth, |Attack, |Decay, |Sustain, |Release, |Linear, |WaveType}, 0);
    check("rst_bus", {bus.BusDataOE, bus.BusError, bus.BusDataOut}, 0);

    // Read ch1 incr byte 2 after reset: 0x00 with OE for exactly one cycle
    rd(16'h0023);
    idle();
    check("rd_after_rst", {bus.BusDataOE, bus.BusError, bus.BusDataOut}, {1'b1, 1'b0, 8'h00});
    idle();
    check("oe_one_cycle", bus.BusDataOE, 0);

    // Atomic commit on ch0 incr
    wr(16'h0001, 8'h56);
    wr(16'h0002, 8'h34);
    idle();
    check("stage_no_commit", Incr[23:0], 24'h000000);
    wr(16'h0003, 8'h12);
    idle();
    check("commit_123456", Incr[23:0], 24'h123456);
    wr(16'h0003, 8'hAB);
    idle();
    check("recommit_AB3456", Incr[23:0], 24'hAB3456);
    check("other_ch_untouched", Incr[95:24], 0);
    // Staging a new low byte must not change committed readback
    wr(16'h0001, 8'h99);
    rd(16'h0001);
    idle();
    check("rd_committed_byte", bus.BusDataOut, 8'h56);

    // Ch2 pulsewidth commit: staging still holds lo=0x99, mid=0x34
    wr(16'h0047, 8'h77);
    idle();
    check("pw_ch2_commit", PulseWidth[71:48], 24'h773499);

    // Ch2 status and back-to-back reads
    Running   = 4'b0100;
    ADSRState = 8'b0010_0000;
    wr(16'h0044, 8'h07);
    wr(16'h0054, 8'hFF);
    idle();
    check("wavetype_low_bits", WaveType[5:4], 2'd3);
    check("linear_low_bit", Linear, 4'b0100);
    rd(16'h0055);
    idle();
    check("status_rd", {bus.BusDataOE, bus.BusDataOut}, {1'b1, 8'h05});
    rd(16'h0044);
    rd(16'h0054);
    check("b2b_rd0", {bus.BusDataOE, bus.BusDataOut}, {1'b1, 8'h03});
    idle();
    check("b2b_rd1", {bus.BusDataOE, bus.BusDataOut}, {1'b1, 8'h01});

    // Global gates
    wr(16'h0080, 8'hFF);
    idle();
    check("gateset", Gate, 4'hF);
    wr(16'h0081, 8'h05);
    idle();
    check("gateclr", Gate, 4'hA);
    check("gateclr_no_err", bus.BusError, 0);
    rd(16'h0080);
    idle();
    check("rd_gateset", {bus.BusError, bus.BusDataOut}, {1'b1, 8'h00});
    rd(16'h0082);
    idle();
    check("rd_id", {bus.BusDataOE, bus.BusError, bus.BusDataOut}, {1'b1, 1'b0, 8'h04});
    wr(16'h0020, 8'h00);
    idle();
    check("ch_gate_write", Gate, 4'h8);

    // Errors
    wr(16'h0055, 8'hFF);
    idle();
    check("wr_status_err", bus.BusError, 1);
    idle();
    check("err_one_cycle", bus.BusError, 0);
    rd(16'h0055);
    idle();
    check("status_unchanged", bus.BusDataOut, 8'h05);
    rd(16'h0056);
    idle();
    check("rd_unmapped_err", {bus.BusError, bus.BusDataOut}, {1'b1, 8'h00});
    wr(16'h0036, 8'h12);
    idle();
    check("wr_unmapped_err", bus.BusError, 1);
    rd(16'h0083);
    idle();
    check("rd_past_glob", {bus.BusDataOE, bus.BusError}, 0);
    wr(16'h0083, 8'h01);
    idle();
    check("wr_past_glob", {bus.BusDataOE, bus.BusError}, 0);
    rd(16'hFFFF);
    idle();
    check("rd_far_addr", {bus.BusDataOE, bus.BusError, bus.BusDataOut}, 0);

    // Reset mid-commit discards staged bytes
    wr(16'h006E, 8'hFF);
    @(negedge BusClock);
    bus.BusValid = 1'b0;
    Reset = 1'b0;
    @(negedge BusClock);
    Reset = 1'b1;
    check("rst2_gate", Gate, 0);
    wr(16'h0070, 8'h01);
    idle();
    check("sustain_after_rst", Sustain[95:72], 24'h010000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
